// File: rtl/counters_pkg.sv
// rtl/counters_pkg.sv - shared types and encodings for the counters subsystem
package counters_pkg;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    SEARCH = 2'd1,
    UP     = 2'd2,
    DOWN   = 2'd3
  } mon_state_t;

  typedef enum logic [1:0] {
    UP_STEP = 2'd0,
    DN_STEP = 2'd1,
    HOLD    = 2'd2,
    JUMP    = 2'd3
  } step_class_t;

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;

  function automatic logic [1:0] dir_of(input mon_state_t st);
    case (st)
      UP:      dir_of = DIR_UP;
      DOWN:    dir_of = DIR_DN;
      default: dir_of = DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/count_step_classify.sv
// rtl/count_step_classify.sv - classifies one count step and detects wraps
module count_step_classify
  import counters_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] count_in,
  output step_class_t      step,
  output logic             is_wrap_up,
  output logic             is_wrap_down
);

  logic [WIDTH-1:0] delta;

  // Modulo subtraction makes max->0 an ordinary up step and 0->max a down step.
  assign delta = count_in - prev;

  always_comb begin
    step = JUMP;
    if (delta == WIDTH'(1))
      step = UP_STEP;
    else if (delta == '1)
      step = DN_STEP;
    else if (delta == '0)
      step = HOLD;
  end

  assign is_wrap_up   = (prev == '1) && (count_in == '0);
  assign is_wrap_down = (prev == '0) && (count_in == '1);

endmodule

// File: rtl/count_sequence_monitor.sv
// rtl/count_sequence_monitor.sv - passive monitor of the up/down counter output bus
module count_sequence_monitor
  import counters_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  output logic [1:0]       dir,
  output logic             locked,
  output logic             wrap_up,
  output logic             wrap_down,
  output logic             reversal,
  output logic             step_err,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [2:0] LOCK_V = 3'(LOCK_CNT);

  mon_state_t       state_q, state_d;
  logic [2:0]       run_q, run_d;
  logic             run_up_q, run_up_d;
  logic [WIDTH-1:0] prev_q;

  step_class_t      step;
  logic             is_wu, is_wd;
  logic             wu_d, wd_d, rev_d, err_d;
  logic [2:0]       run_inc;

  count_step_classify #(.WIDTH(WIDTH)) u_classify (
    .prev         (prev_q),
    .count_in     (count_in),
    .step         (step),
    .is_wrap_up   (is_wu),
    .is_wrap_down (is_wd)
  );

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    run_up_d = run_up_q;
    wu_d     = 1'b0;
    wd_d     = 1'b0;
    rev_d    = 1'b0;
    err_d    = 1'b0;
    run_inc  = run_q + 3'd1;

    if (state_q != INIT) begin
      wu_d = is_wu;
      wd_d = is_wd;
    end

    case (state_q)
      INIT: begin
        state_d = SEARCH;
        run_d   = 3'd0;
      end
      SEARCH: begin
        case (step)
          UP_STEP, DN_STEP: begin
            // A step against the current run direction starts a fresh run of 1.
            if (run_q != 3'd0 && run_up_q == (step == UP_STEP))
              run_d = run_inc;
            else
              run_d = 3'd1;
            run_up_d = (step == UP_STEP);
            if (run_d == LOCK_V)
              state_d = (step == UP_STEP) ? UP : DOWN;
          end
          JUMP: begin
            err_d = 1'b1;
            run_d = 3'd0;
          end
          default: ;
        endcase
      end
      UP, DOWN: begin
        case (step)
          UP_STEP: begin
            if (state_q == DOWN) begin
              rev_d   = 1'b1;
              state_d = UP;
            end
          end
          DN_STEP: begin
            if (state_q == UP) begin
              rev_d   = 1'b1;
              state_d = DOWN;
            end
          end
          JUMP: begin
            err_d   = 1'b1;
            state_d = SEARCH;
            run_d   = 3'd0;
          end
          default: ;
        endcase
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= INIT;
      run_q     <= 3'd0;
      run_up_q  <= 1'b0;
      prev_q    <= '0;
      dir       <= DIR_NONE;
      locked    <= 1'b0;
      wrap_up   <= 1'b0;
      wrap_down <= 1'b0;
      reversal  <= 1'b0;
      step_err  <= 1'b0;
      wrap_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      run_up_q  <= run_up_d;
      prev_q    <= count_in;
      dir       <= dir_of(state_d);
      locked    <= (state_d == UP) || (state_d == DOWN);
      wrap_up   <= wu_d;
      wrap_down <= wd_d;
      reversal  <= rev_d;
      step_err  <= err_d;
      if (wu_d || wd_d)
        wrap_cnt <= wrap_cnt + 1'b1;
      // Error count saturates so a long fault burst never reads as a small number.
      if (err_d && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_count_sequence_monitor.sv
// tb/tb_count_sequence_monitor.sv - directed self-checking bench for count_sequence_monitor
module tb_count_sequence_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] count_in;
  logic [1:0] dir;
  logic       locked, wrap_up, wrap_down, reversal, step_err;
  logic [7:0] wrap_cnt, err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  count_sequence_monitor #(.WIDTH(4), .LOCK_CNT(2), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .count_in  (count_in),
    .dir       (dir),
    .locked    (locked),
    .wrap_up   (wrap_up),
    .wrap_down (wrap_down),
    .reversal  (reversal),
    .step_err  (step_err),
    .wrap_cnt  (wrap_cnt),
    .err_cnt   (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic flags(input string tag, input logic [1:0] d, input logic l, input logic wu,
                       input logic wd, input logic rv, input logic se);
    check({tag, ".dir"},       32'(dir),       32'(d));
    check({tag, ".locked"},    32'(locked),    32'(l));
    check({tag, ".wrap_up"},   32'(wrap_up),   32'(wu));
    check({tag, ".wrap_down"}, 32'(wrap_down), 32'(wd));
    check({tag, ".reversal"},  32'(reversal),  32'(rv));
    check({tag, ".step_err"},  32'(step_err),  32'(se));
  endtask

  task automatic drive(input logic [3:0] v);
    @(negedge clk);
    count_in = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    count_in = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    flags("reset", 2'b00, 0, 0, 0, 0, 0);
    check("reset.wrap_cnt", 32'(wrap_cnt), 32'd0);
    check("reset.err_cnt",  32'(err_cnt),  32'd0);

    reset = 1'b1;
    drive(4'd0);  flags("init0",   2'b00, 0, 0, 0, 0, 0);
    drive(4'd1);  flags("search1", 2'b00, 0, 0, 0, 0, 0);
    drive(4'd2);  flags("lock_up", 2'b01, 1, 0, 0, 0, 0);
    drive(4'd3);  flags("up3",     2'b01, 1, 0, 0, 0, 0);
    check("up3.wrap_cnt", 32'(wrap_cnt), 32'd0);

    for (int v = 4; v <= 15; v++) drive(4'(v));
    flags("up15", 2'b01, 1, 0, 0, 0, 0);
    drive(4'd0);  flags("wrap_up", 2'b01, 1, 1, 0, 0, 0);
    check("wrap_up.wrap_cnt", 32'(wrap_cnt), 32'd1);
    drive(4'd1);  flags("post_wrap", 2'b01, 1, 0, 0, 0, 0);

    for (int v = 2; v <= 6; v++) drive(4'(v));
    drive(4'd5);  flags("reversal", 2'b10, 1, 0, 0, 1, 0);
    drive(4'd4);  flags("down4",    2'b10, 1, 0, 0, 0, 0);

    for (int v = 3; v >= 0; v--) drive(4'(v));
    drive(4'd15); flags("wrap_dn", 2'b10, 1, 0, 1, 0, 0);
    check("wrap_dn.wrap_cnt", 32'(wrap_cnt), 32'd2);

    for (int v = 14; v >= 3; v--) drive(4'(v));
    flags("down3", 2'b10, 1, 0, 0, 0, 0);
    drive(4'd7);  flags("jump", 2'b00, 0, 0, 0, 0, 1);
    check("jump.err_cnt", 32'(err_cnt), 32'd1);
    drive(4'd8);  flags("relock8", 2'b00, 0, 0, 0, 0, 0);
    drive(4'd9);  flags("relock9", 2'b01, 1, 0, 0, 0, 0);

    for (int v = 10; v <= 15; v++) drive(4'(v));
    for (int v = 0; v <= 4; v++) drive(4'(v));
    drive(4'd4);  flags("hold1", 2'b01, 1, 0, 0, 0, 0);
    drive(4'd4);  flags("hold2", 2'b01, 1, 0, 0, 0, 0);
    check("hold.wrap_cnt", 32'(wrap_cnt), 32'd3);
    check("hold.err_cnt",  32'(err_cnt),  32'd1);

    @(negedge clk);
    reset    = 1'b0;
    count_in = 4'd5;
    @(posedge clk);
    #1;
    flags("mid_reset", 2'b00, 0, 0, 0, 0, 0);
    check("mid_reset.wrap_cnt", 32'(wrap_cnt), 32'd0);
    check("mid_reset.err_cnt",  32'(err_cnt),  32'd0);
    reset = 1'b1;
    drive(4'd9);  flags("release9", 2'b00, 0, 0, 0, 0, 0);
    check("release9.err_cnt", 32'(err_cnt), 32'd0);
    drive(4'd10); flags("rel10", 2'b00, 0, 0, 0, 0, 0);
    drive(4'd11); flags("rel11", 2'b01, 1, 0, 0, 0, 0);

    // Toggling 15<->0 while locked wraps on every sample and reverses from the second on.
    for (int v = 12; v <= 15; v++) drive(4'(v));
    for (int i = 1; i <= 256; i++) begin
      drive((i % 2 == 1) ? 4'd0 : 4'd15);
      if (i == 1)   flags("toggle1", 2'b01, 1, 1, 0, 0, 0);
      if (i == 2)   flags("toggle2", 2'b10, 1, 0, 1, 1, 0);
      if (i == 3)   flags("toggle3", 2'b01, 1, 1, 0, 1, 0);
      if (i == 255) check("wrap_cnt_255", 32'(wrap_cnt), 32'd255);
      if (i == 256) check("wrap_cnt_roll", 32'(wrap_cnt), 32'd0);
    end

    for (int i = 1; i <= 256; i++) begin
      drive((i % 2 == 1) ? 4'd7 : 4'd15);
      if (i == 1)   flags("jump_locked", 2'b00, 0, 0, 0, 0, 1);
      if (i == 2)   flags("jump_search", 2'b00, 0, 0, 0, 0, 1);
      if (i == 255) check("err_cnt_255", 32'(err_cnt), 32'd255);
      if (i == 256) begin
        check("err_cnt_sat", 32'(err_cnt), 32'd255);
        check("err_sat.step_err", 32'(step_err), 32'd1);
      end
    end
    check("final.wrap_cnt", 32'(wrap_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/count_sequence_monitor.md
# count_sequence_monitor

Passive monitor on the output bus of the 4-bit up/down counter: samples the count every clock, decodes step direction, and flags wraps, reversals and illegal jumps. It sits beside the counter in the counters subsystem and in its benches, consuming the counter's output the way a receiver consumes a transmitter. It gives direction lock status and event counters without access to the counter's `up_down` control.

## Interface
- `WIDTH`, 4: width of the monitored count bus.
- `LOCK_CNT`, 2: consecutive same-direction steps required to lock, range 1..7.
- `CNT_W`, 8: width of the wrap and error counters.

- `clk`, in, 1: sole clock, rising edge.
- `reset`, in, 1: synchronous, active-low; sampled on the `clk` rising edge.
- `count_in`, in, WIDTH: monitored count value.
- `dir`, out, 2: 00 none, 01 up, 10 down.
- `locked`, out, 1: direction locked.
- `wrap_up`, out, 1: one-cycle pulse on the max→0 step.
- `wrap_down`, out, 1: one-cycle pulse on the 0→max step.
- `reversal`, out, 1: one-cycle pulse on a locked direction change.
- `step_err`, out, 1: one-cycle pulse on an illegal jump.
- `wrap_cnt`, out, CNT_W: total wraps in either direction, modulo 2^CNT_W.
- `err_cnt`, out, CNT_W: total step errors, saturating at all-ones.

## Operation
- Registers:
  - `prev`: the previous sample.
  - FSM state: INIT, SEARCH, UP or DOWN.
  - `run`: 3-bit run counter.
- Step delta `d = count_in - prev`, modulo 2^WIDTH, classified as:
  - d==1 → UP_STEP
  - d==all-ones → DN_STEP
  - d==0 → HOLD
  - otherwise → JUMP
- INIT: capture `prev`, no classification, go to SEARCH.
- SEARCH (`dir`=00, `locked`=0):
  - UP_STEP or DN_STEP in the same direction as the current run: `run`+1. A step in the other direction restarts `run` at 1 in that direction.
  - When `run` reaches LOCK_CNT, go to UP or DOWN.
  - HOLD leaves `run` unchanged.
  - JUMP asserts `step_err` and clears `run`.
- UP (`dir`=01, `locked`=1):
  - UP_STEP: stay in UP.
  - DN_STEP: assert `reversal`, go to DOWN, `locked` stays 1.
  - HOLD: stay in UP.
  - JUMP: assert `step_err`, go to SEARCH, clear `run`.
- DOWN: mirror of UP.
- Wraps are detected in every state except INIT:
  - `wrap_up`: prev==max and count_in==0.
  - `wrap_down`: prev==0 and count_in==max.
  - Either wrap increments `wrap_cnt`.
- `prev` is updated every non-reset cycle.
- At most one of `wrap_up` or `wrap_down` is asserted per cycle. A wrap may coincide with `reversal`, e.g. UP state, prev 0 → 15.

## Timing
- All outputs are registered. The event decoded from sample k (the `count_in` captured at edge k, compared with sample k−1) appears on the outputs after edge k and lasts exactly one cycle for pulses.
- Lock: the sample completing the LOCK_CNT-th step raises `locked` and `dir` after that edge.
- Reset asserted (`reset`=0 at an edge):
  - All outputs go to 0, including `dir`=00, `wrap_cnt` and `err_cnt`.
  - State goes to INIT, `run` and `prev` go to 0.
- Reset mid-operation discards history. The first sample after release is only captured; it produces no flags, even if it differs arbitrarily from pre-reset values.
- `wrap_cnt` rolls from all-ones to 0.
- `err_cnt` holds at all-ones.

## Structure
- Shared package `counters_pkg`:
  - state enum (INIT, SEARCH, UP, DOWN)
  - step-class enum (UP_STEP, DN_STEP, HOLD, JUMP)
  - `dir` encodings: DIR_NONE=00, DIR_UP=01, DIR_DN=10
- Sub-module `count_step_classify`: combinational, WIDTH-parameterised. Inputs `prev` and `count_in`; outputs step class, `is_wrap_up` and `is_wrap_down`.
- The top level holds the FSM, run counter, `prev` register and output counters.

## Test plan
- Hold `reset`=0 for 2 cycles, then drive 0,1,2,3 → `locked`=1, `dir`=01 after the edge sampling 2. No pulses; `wrap_cnt`=0.
- Locked up, drive 14,15,0,1 → one `wrap_up` pulse after the edge sampling 0; `wrap_cnt`=1; `dir` stays 01.
- Locked up at 6, drive 5,4 → `reversal` pulses once after the edge sampling 5; `dir`=10, `locked` stays 1.
- Locked down, drive 1,0,15 → `wrap_down` pulse plus `wrap_cnt`+1; no `reversal`.
- Locked, drive 3 then 7 → `step_err` pulse, `err_cnt`=1, `locked`=0, `dir`=00. Relock after 2 further up steps (8,9).
- Hold 4,4,4 while locked → no pulses, lock retained.
- Reset mid-run with `wrap_cnt`=3, then release with count_in=9 → all outputs 0 and no flags on the first sample. A following 10,11 relocks up.
